// File: rtl/dct_mem_sequencer_if.sv
// Host-control and SRAM-side signal bundle for the DCT memory sequencer.
// The master drives the pass request; the slave (sequencer) owns both SRAM buses.
interface dct_mem_sequencer_if #(
  parameter int ADDR_W = 15,
  parameter int BLK_W  = 12
);
  logic              start;
  logic [BLK_W-1:0]  num_blocks;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;
  logic              hold;
  logic [ADDR_W-1:0] addr_in;
  logic              nce_in;
  logic              dct_in_valid;
  logic [ADDR_W-1:0] addr_out;
  logic              nce_out;
  logic              nwrt_out;
  logic              busy;
  logic              done;

  modport master (
    output start, num_blocks, in_base, out_base, hold,
    input  addr_in, nce_in, dct_in_valid, addr_out, nce_out, nwrt_out, busy, done
  );

  modport slave (
    input  start, num_blocks, in_base, out_base, hold,
    output addr_in, nce_in, dct_in_valid, addr_out, nce_out, nwrt_out, busy, done
  );
endinterface

// File: rtl/dct_mem_sequencer.sv
// Sequences one DCT pass: streams 8-word blocks from the input SRAM into the DCT
// and writes results to the output SRAM at the latency-aligned cycle.
module dct_mem_sequencer #(
  parameter int ADDR_W  = 15,
  parameter int BLK_W   = 12,
  parameter int DCT_LAT = 20
) (
  input  logic                clk,
  input  logic                reset,
  dct_mem_sequencer_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  total_words;
  logic [ADDR_W-1:0] in_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DCT_LAT-1:0] vsr;
  logic              nce_out_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_fire;
  logic              last_rd;

  // hold must veto the read in the same cycle it is seen, so the read strobe
  // is decoded from registered state rather than registered itself.
  always_comb begin
    rd_fire = (state == READ) && ((rd_cnt[2:0] != 3'd0) || !bus.hold);
    last_rd = rd_fire && (rd_cnt == total_words - CNT_W'(1));
  end

  assign bus.addr_in      = in_base_q + rd_cnt[ADDR_W-1:0];
  assign bus.nce_in       = ~rd_fire;
  assign bus.dct_in_valid = vsr[0];
  assign bus.addr_out     = addr_out_q;
  assign bus.nce_out      = nce_out_q;
  assign bus.nwrt_out     = nce_out_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      total_words <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      addr_out_q  <= '0;
      vsr         <= '0;
      nce_out_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // vsr[0] is dct_in_valid; the write stage registers vsr[DCT_LAT-1],
      // giving DCT_LAT cycles from dct_in_valid to the write strobe.
      vsr       <= (vsr << 1) | DCT_LAT'(rd_fire);
      nce_out_q <= ~vsr[DCT_LAT-1];
      if (vsr[DCT_LAT-1]) begin
        addr_out_q <= out_base_q + wr_cnt[ADDR_W-1:0];
        wr_cnt     <= wr_cnt + CNT_W'(1);
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_blocks != '0) begin
              total_words <= CNT_W'({bus.num_blocks, 3'b000});
              in_base_q   <= bus.in_base;
              out_base_q  <= bus.out_base;
              rd_cnt      <= '0;
              wr_cnt      <= '0;
              busy_q      <= 1'b1;
              state       <= READ;
            end else begin
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        READ: begin
          if (last_rd) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_cnt == total_words) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_mem_sequencer.sv
// Directed and randomized passes of dct_mem_sequencer checked cycle by cycle
// against an event-list model of read/write/done timing.
module tb_dct_mem_sequencer;
  localparam int ADDR_W  = 15;
  localparam int BLK_W   = 12;
  localparam int DCT_LAT = 20;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   last_ao = 0;

  always #5 clk = ~clk;

  dct_mem_sequencer_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) bus ();

  dct_mem_sequencer #(
    .ADDR_W (ADDR_W),
    .BLK_W  (BLK_W),
    .DCT_LAT(DCT_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, expv);
    end
  endtask

  task automatic drive(input logic s, input int n, input int ib, input int ob, input logic h);
    bus.start      = s;
    bus.num_blocks = BLK_W'(n);
    bus.in_base    = ADDR_W'(ib);
    bus.out_base   = ADDR_W'(ob);
    bus.hold       = h;
  endtask

  // Compare every output of cycle c against the model's event lists.
  task automatic check_cycle(input int c, input int n, input int ib, input int ob,
                             input int done_c, input int rst_cyc,
                             input int rd_at[int], input int wr_at[int]);
    bit idle, e_rd, e_dv, e_wr;
    idle = (rst_cyc > 0) && (c >= rst_cyc);
    e_rd = !idle && rd_at.exists(c);
    e_dv = !idle && rd_at.exists(c - 1);
    e_wr = !idle && wr_at.exists(c);
    if (e_wr) last_ao = (ob + wr_at[c]) & AMASK;
    if (idle) last_ao = 0;
    chk("nce_in", c, 32'(bus.nce_in), 32'(!e_rd));
    if (e_rd) chk("addr_in", c, 32'(bus.addr_in), 32'((ib + rd_at[c]) & AMASK));
    if (idle) chk("addr_in_rst", c, 32'(bus.addr_in), 32'd0);
    chk("dct_in_valid", c, 32'(bus.dct_in_valid), 32'(e_dv));
    chk("nce_out", c, 32'(bus.nce_out), 32'(!e_wr));
    chk("nwrt_out", c, 32'(bus.nwrt_out), 32'(!e_wr));
    chk("addr_out", c, 32'(bus.addr_out), 32'(last_ao));
    chk("busy", c, 32'(bus.busy), 32'(!idle && n > 0 && c >= 1 && c < done_c));
    chk("done", c, 32'(bus.done), 32'(!idle && c == done_c));
  endtask

  // One pass, start high in cycle 0. hold forced in [h_from, h_from+h_len) plus
  // random holds at h_pct%; stray starts in [s_from, s_to] at s_pct%; optional
  // asynchronous reset in cycle rst_cyc (0 = none).
  task automatic run_pass(input int n, input int ib, input int ob,
                          input int h_from, input int h_len, input int h_pct,
                          input int s_from, input int s_to, input int s_pct,
                          input int rst_cyc);
    bit hp[512];
    int rd_at[int];
    int wr_at[int];
    int cur, done_c, end_c;
    logic s;
    for (int c = 0; c < 512; c++)
      hp[c] = ((c >= h_from) && (c < h_from + h_len)) || ($urandom_range(99) < h_pct);
    // Blocks start at the first unheld cycle; each block's 8 reads are contiguous.
    cur = 1;
    for (int b = 0; b < n; b++) begin
      while (cur < 512 && hp[cur]) cur++;
      for (int k = 0; k < 8; k++) begin
        rd_at[cur + k] = 8 * b + k;
        wr_at[cur + k + 1 + DCT_LAT] = 8 * b + k;
      end
      cur += 8;
    end
    done_c = (n == 0) ? 1 : cur + DCT_LAT + 1;
    end_c  = (rst_cyc > 0) ? rst_cyc + DCT_LAT + 12 : done_c + 2;

    @(posedge clk);
    #1 drive(1'b1, n, ib, ob, hp[0]);
    #4 check_cycle(0, n, ib, ob, done_c, rst_cyc, rd_at, wr_at);
    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk);
      s = (c >= s_from) && (c <= s_to) && (c <= done_c) &&
          !(rst_cyc > 0 && c >= rst_cyc) && ($urandom_range(99) < s_pct);
      #1 drive(s, int'($urandom_range(4095)), int'($urandom & AMASK),
               int'($urandom & AMASK), (c < 512) ? hp[c] : 1'b0);
      if (c == rst_cyc) begin
        #1 reset = 1'b0;
        #3 check_cycle(c, n, ib, ob, done_c, rst_cyc, rd_at, wr_at);
        #3 reset = 1'b1;
      end else begin
        #4 check_cycle(c, n, ib, ob, done_c, rst_cyc, rd_at, wr_at);
      end
    end
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #5;
    chk("rst_nce_in", -1, 32'(bus.nce_in), 32'd1);
    chk("rst_addr_in", -1, 32'(bus.addr_in), 32'd0);
    chk("rst_nce_out", -1, 32'(bus.nce_out), 32'd1);
    chk("rst_nwrt_out", -1, 32'(bus.nwrt_out), 32'd1);
    chk("rst_addr_out", -1, 32'(bus.addr_out), 32'd0);
    chk("rst_dv", -1, 32'(bus.dct_in_valid), 32'd0);
    chk("rst_busy", -1, 32'(bus.busy), 32'd0);
    chk("rst_done", -1, 32'(bus.done), 32'd0);
    reset = 1'b1;

    // Single block at base 0.
    run_pass(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Two blocks with a 3-cycle hold at the block boundary.
    run_pass(2, 0, 0, 9, 3, 0, 0, 0, 0, 0);
    // Mid-block hold has no effect.
    run_pass(1, 0, 0, 4, 2, 0, 0, 0, 0, 0);
    // Address wrap on both SRAMs.
    run_pass(1, 32764, 32766, 0, 0, 0, 0, 0, 0, 0);
    // Zero blocks, with a start during the FIN cycle.
    run_pass(0, 100, 200, 0, 0, 0, 1, 1, 100, 0);
    // Starts during a running pass are ignored.
    run_pass(5, 1000, 2000, 0, 0, 0, 3, 40, 100, 0);
    // Asynchronous reset mid-write, then a clean pass.
    run_pass(1, 0, 0, 0, 0, 0, 0, 0, 0, 25);
    run_pass(1, 50, 60, 0, 0, 0, 0, 0, 0, 0);
    // Randomized passes with random holds and stray starts.
    for (int i = 0; i < 8; i++)
      run_pass(int'($urandom_range(4, 1)), int'($urandom & AMASK), int'($urandom & AMASK),
               0, 0, 25, 1, 600, 20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dct_mem_sequencer.md
Name: dct_mem_sequencer

Overview:
- Sequences one DCT pass: streams 8-word (8x8-pixel) blocks from the input SRAM into the 2-D DCT datapath and writes DCT results into the output SRAM at the latency-aligned cycle.
- Owns both SRAM address buses and both chip enables, plus the output-SRAM write strobe.
- Replaces the free-running address counters; a host issues start/length/base and observes busy/done.

Parameters:
- ADDR_W, 15, SRAM word address width (RA = addr[14:4], CA = addr[3:0]).
- BLK_W, 12, width of block-count input (max 4095 blocks).
- DCT_LAT, 20, cycles from dct_in_valid to the matching DCT output word (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request, honoured only in IDLE.
- num_blocks  in  BLK_W  blocks to process; sampled on accepted start.
- in_base  in  ADDR_W  first input-SRAM word; sampled on accepted start.
- out_base  in  ADDR_W  first output-SRAM word; sampled on accepted start.
- hold  in  1  pause request, honoured only at block boundaries.
- addr_in  out  ADDR_W  input-SRAM address.
- nce_in  out  1  input-SRAM chip enable, active-low.
- dct_in_valid  out  1  data_in from SRAM is valid this cycle.
- addr_out  out  ADDR_W  output-SRAM address.
- nce_out  out  1  output-SRAM chip enable, active-low.
- nwrt_out  out  1  output-SRAM write enable, active-low.
- busy  out  1  pass in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, addr_in=0, addr_out=0, nce_in=1, nce_out=1, nwrt_out=1, dct_in_valid=0, busy=0, done=0. Reset mid-pass abandons the pass; no further SRAM access until a new start.
- States: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 with num_blocks>0: latch the inputs, clear counters, go to READ.
  - start=1 with num_blocks=0: go to FIN directly. No SRAM access occurs.
  - start ignored in every state except IDLE.
- READ:
  - Each cycle either issues a read (rd_fire=1: nce_in=0, addr_in = in_base + rd_cnt, rd_cnt++) or idles (nce_in=1).
  - Word index = rd_cnt[2:0]. hold is sampled only when the word index is 0. If hold=1, no read is issued that cycle.
  - Once a block starts, its 8 reads are issued on 8 consecutive cycles; hold is ignored mid-block.
  - After the read of word 8*num_blocks-1, go to DRAIN.
- Addresses are computed modulo 2^ADDR_W, so base + offset wraps past 32767 to 0.
- Read pipeline:
  - SRAM read latency is 1 cycle, so dct_in_valid is rd_fire delayed 1 cycle.
  - wr_fire is dct_in_valid delayed DCT_LAT cycles, implemented as a valid shift register, so gaps from hold are preserved.
- Write: when wr_fire=1, nce_out=0, nwrt_out=0, addr_out = out_base + wr_cnt, wr_cnt++. Otherwise nce_out=1 and nwrt_out=1; addr_out holds its last value.
- DRAIN: wait until wr_cnt = 8*num_blocks, then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start in the FIN cycle is ignored.
- busy=1 in READ and DRAIN only.
- Timing (start high in cycle S, no hold, N blocks):
  - Reads occur in cycles S+1..S+8N.
  - Writes occur in cycles S+2+DCT_LAT..S+8N+1+DCT_LAT.
  - done pulses in cycle S+8N+2+DCT_LAT.
- Counters are ADDR_W+1 bits wide, so 4095 blocks (32760 words) do not overflow.

Test Plan:
- Reset, then start with num_blocks=1, in_base=0, out_base=0, DCT_LAT=20 (start in cycle 0):
  - addr_in 0..7 with nce_in=0 in cycles 1..8.
  - dct_in_valid high in cycles 2..9.
  - addr_out 0..7 with nwrt_out=nce_out=0 in cycles 22..29.
  - done=1 in cycle 30 only; busy=1 in cycles 1..29.
- num_blocks=2, hold=1 at cycle 9 (block boundary) for 3 cycles:
  - reads for words 8..15 occur in cycles 12..19.
  - writes show the same 3-cycle gap: words 0..7 in cycles 22..29, words 8..15 in cycles 33..40.
- hold=1 asserted at cycle 4 (mid-block): no effect; reads stay contiguous in cycles 1..8.
- in_base=32764, out_base=32766, num_blocks=1:
  - addr_in sequence 32764,32765,32766,32767,0,1,2,3.
  - addr_out sequence 32766,32767,0..5.
- num_blocks=0: nce_in and nce_out stay 1 throughout, busy never rises, done=1 in cycle 1. A start asserted in cycles 3..40 of a running pass is ignored.
- reset=0 asserted asynchronously at cycle 25 of a 1-block pass:
  - outputs return to reset values immediately.
  - no further writes and no done pulse.
  - a subsequent start runs a clean pass.
